bldc_commutator: RTL
====================

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 SHALL have parameter PWM_W, default 8, meaning PWM counter and duty width in bits.
REQ-002 SHALL have parameter DEBOUNCE, default 16, meaning clock cycles a hall code must stay stable before acceptance (>=1).
REQ-003 SHALL have parameter DEADTIME, default 8, meaning clock cycles of all-gates-off blanking at every commutation change (>=1).
REQ-004 SHALL have parameter SPD_W, default 24, meaning hall-period counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port motor_en  in  1  run request; low forces IDLE.
REQ-008 SHALL have port dir  in  1  0 = forward, 1 = reverse.
REQ-009 SHALL have port duty  in  PWM_W  high-side PWM duty.
REQ-010 SHALL have ports hallA, hallB, hallC  in  1 each  asynchronous hall sensor inputs.
REQ-011 SHALL have ports phaseA, phaseB, phaseC  out  1 each  high-side gate drives.
REQ-012 SHALL have ports phaseA_lo, phaseB_lo, phaseC_lo  out  1 each  low-side gate drives.
REQ-013 SHALL have port fault  out  1  latched invalid-hall fault.
REQ-014 SHALL have ports hall_period  out  SPD_W, and period_valid  out  1 (present only per REQ-029).

Function
REQ-015 Each hall input SHALL pass a 2-flop synchroniser; the code H = {A,B,C} SHALL be accepted only after it has been identical for DEBOUNCE consecutive cycles.
REQ-016 Forward table (H: high/low phase): 101: A/B; 100: A/C; 110: B/C; 010: B/A; 011: C/A; 001: C/B. Reverse SHALL swap high and low.
REQ-017 A free-running PWM_W-bit counter SHALL wrap from all-ones to 0; pwm_on = (counter < duty). duty = 0 means never on; all-ones means on for 2^PWM_W-1 of 2^PWM_W cycles.
REQ-018 In RUN, the selected high-side output SHALL equal pwm_on, the selected low-side output SHALL be held high, and all others SHALL be low.
REQ-019 At most one output per phase SHALL be high in any cycle.
REQ-020 The FSM SHALL have states IDLE, ALIGN, RUN, BLANK and FAULT.
REQ-021 IDLE: all outputs low; on motor_en = 1 go to ALIGN.
REQ-022 ALIGN: outputs low; when an accepted valid code exists go to BLANK; an accepted 000 or 111 SHALL go to FAULT.
REQ-023 RUN: when the accepted code or dir changes go to BLANK; outputs SHALL be low in the same cycle the change is registered.
REQ-024 BLANK: outputs low for exactly DEADTIME cycles, then RUN with the table entry for the current code and dir. A further change during BLANK SHALL restart the DEADTIME count.
REQ-025 An accepted 000 or 111 in any state except IDLE SHALL go to FAULT; FAULT sets fault = 1 with all outputs low and is left only via motor_en = 0 (to IDLE, fault cleared) or reset.
REQ-026 motor_en = 0 in any state SHALL force IDLE on the next edge, with outputs low from that edge onward.
REQ-027 Latency from a stable hall edge at the pins to BLANK entry SHALL be 2 + DEBOUNCE + 1 cycles.

Reset
REQ-028 When rst is high, the block SHALL be asynchronously in IDLE with the synchronisers, debounce counter, PWM counter and speed counter cleared; all gate outputs, fault, hall_period and period_valid SHALL be 0.

Configuration
REQ-029 With BLDC_SPEED_MEAS_EN defined, an SPD_W-bit counter SHALL count cycles between successive accepted valid hall codes and saturate at all-ones; on each accepted change it SHALL load hall_period and pulse period_valid for 1 cycle, then restart at 1. The counter SHALL be cleared outside RUN/BLANK.
REQ-030 Without BLDC_SPEED_MEAS_EN, hall_period and period_valid SHALL be tied to 0 and no speed counter SHALL be synthesised.

Verification
REQ-031 rst = 1 mid-RUN with duty = 128 -> all six gates 0 in the same cycle and fault = 0; state returns to IDLE.
REQ-032 motor_en = 1, dir = 0, H = 101, duty = 64, PWM_W = 8 -> after ALIGN and 8 BLANK cycles, phaseA is high 64 of every 256 cycles, phaseB_lo = 1 constantly, all others 0.
REQ-033 Step H from 101 to 100 in RUN -> all gates 0 for 8 cycles starting 19 cycles after the pin edge, then phaseA is PWM and phaseC_lo = 1; a 10-cycle glitch to 110 -> no change.
REQ-034 dir toggled 0 to 1 with H = 110 -> BLANK for 8 cycles, then phaseC is PWM and phaseB_lo = 1.
REQ-035 H forced to 111 for more than 16 cycles -> fault = 1 and all gates 0; H restored alone -> still FAULT; motor_en pulsed low -> fault = 0, IDLE.
REQ-036 BLDC_SPEED_MEAS_EN defined, hall edges 1000 cycles apart -> period_valid pulses with hall_period = 1000; with SPD_W = 8 -> hall_period = 255.

Source files
------------

// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step trapezoidal BLDC commutation controller.
// Hall inputs are synchronised and debounced, then decoded into one high-side
// (PWM) and one low-side (held on) gate per step, with dead-time blanking
// between steps and a latched fault for impossible hall codes.
// Optional feature: define BLDC_SPEED_MEAS_EN to build the hall-period
// counter that drives hall_period / period_valid; otherwise both read 0.
module bldc_commutator #(
   parameter int PWM_W    = 8,
   parameter int DEBOUNCE = 16,
   parameter int DEADTIME = 8,
   parameter int SPD_W    = 24
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             motor_en,
   input  logic             dir,
   input  logic [PWM_W-1:0] duty,
   input  logic             hallA,
   input  logic             hallB,
   input  logic             hallC,
   output logic             phaseA,
   output logic             phaseB,
   output logic             phaseC,
   output logic             phaseA_lo,
   output logic             phaseB_lo,
   output logic             phaseC_lo,
   output logic             fault,
   output logic [SPD_W-1:0] hall_period,
   output logic             period_valid
);

   localparam int DB_W = $clog2(DEBOUNCE + 1) + 1;
   localparam int DT_W = $clog2(DEADTIME) + 1;

   typedef enum logic [2:0] {IDLE, ALIGN, RUN, BLANK, FAULT} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [2:0]       r_hallMeta;
   logic [2:0]       r_hallSync;
   logic [2:0]       r_hallLast;
   logic [1:0]       r_syncFill;
   logic [DB_W-1:0]  r_holdCnt;
   logic [DB_W-1:0]  w_held;
   logic             w_accept;
   logic [2:0]       r_accCode;
   logic             r_accValid;
   logic             w_accInvalid;
   logic [2:0]       r_curCode;
   logic             r_curDir;
   logic             w_changed;
   logic [DT_W-1:0]  r_blankCnt;
   logic [PWM_W-1:0] r_pwmCnt;
   logic             w_pwmOn;
   logic [2:0]       w_hiSel;
   logic [2:0]       w_loSel;
   logic             w_drive;

   // How many consecutive cycles the synchronised code has held, counting the
   // current one; zero until the synchroniser holds real pin samples.
   always_comb begin
      w_held = '0;
      if (r_syncFill[1]) begin
         if (r_hallSync != r_hallLast)
            w_held = DB_W'(1);
         else if (r_holdCnt != DB_W'(DEBOUNCE))
            w_held = r_holdCnt + 1'b1;
         else
            w_held = r_holdCnt;
      end
   end

   assign w_accept     = (w_held == DB_W'(DEBOUNCE));
   assign w_accInvalid = r_accValid && ((r_accCode == 3'b000) || (r_accCode == 3'b111));
   assign w_changed    = (r_accCode != r_curCode) || (dir != r_curDir);

   // Two-flop hall synchroniser followed by the stability counter that accepts a code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hallMeta <= '0;
         r_hallSync <= '0;
         r_hallLast <= '0;
         r_syncFill <= '0;
         r_holdCnt  <= '0;
         r_accCode  <= '0;
         r_accValid <= 1'b0;
      end else begin
         r_hallMeta <= {hallA, hallB, hallC};
         r_hallSync <= r_hallMeta;
         r_hallLast <= r_hallSync;
         r_syncFill <= {r_syncFill[0], 1'b1};
         r_holdCnt  <= w_held;
         if (w_accept) begin
            r_accCode  <= r_hallSync;
            r_accValid <= 1'b1;
         end
      end
   end

   // Free-running PWM carrier; wraps naturally from all-ones to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pwmCnt <= '0;
      else
         r_pwmCnt <= r_pwmCnt + 1'b1;
   end

   assign w_pwmOn = (r_pwmCnt < duty);

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   // Next-state logic; dropping motor_en overrides everything else.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (motor_en) w_nextState = ALIGN;
         ALIGN:   if (w_accInvalid) w_nextState = FAULT;
                  else if (r_accValid) w_nextState = BLANK;
         RUN:     if (w_accInvalid) w_nextState = FAULT;
                  else if (w_changed) w_nextState = BLANK;
         BLANK:   if (w_accInvalid) w_nextState = FAULT;
                  else if (!w_changed && (r_blankCnt == DT_W'(DEADTIME - 1))) w_nextState = RUN;
         FAULT:   w_nextState = FAULT;
         default: w_nextState = IDLE;
      endcase
      if (!motor_en)
         w_nextState = IDLE;
   end

   // Snapshot code and direction when blanking starts or restarts; count dead-time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_curCode  <= '0;
         r_curDir   <= 1'b0;
         r_blankCnt <= '0;
      end else if ((w_nextState == BLANK) && ((r_state != BLANK) || w_changed)) begin
         r_curCode  <= r_accCode;
         r_curDir   <= dir;
         r_blankCnt <= '0;
      end else if (r_state == BLANK) begin
         r_blankCnt <= r_blankCnt + 1'b1;
      end
   end

   // Commutation table (bit 2 = A, bit 1 = B, bit 0 = C); reverse swaps the sides.
   always_comb begin
      w_hiSel = 3'b000;
      w_loSel = 3'b000;
      case (r_curCode)
         3'b101:  begin w_hiSel = 3'b100; w_loSel = 3'b010; end
         3'b100:  begin w_hiSel = 3'b100; w_loSel = 3'b001; end
         3'b110:  begin w_hiSel = 3'b010; w_loSel = 3'b001; end
         3'b010:  begin w_hiSel = 3'b010; w_loSel = 3'b100; end
         3'b011:  begin w_hiSel = 3'b001; w_loSel = 3'b100; end
         3'b001:  begin w_hiSel = 3'b001; w_loSel = 3'b010; end
         default: begin w_hiSel = 3'b000; w_loSel = 3'b000; end
      endcase
      if (r_curDir) begin
         {w_hiSel, w_loSel} = {w_loSel, w_hiSel};
      end
   end

   assign w_drive   = (r_state == RUN);
   assign phaseA    = w_drive & w_hiSel[2] & w_pwmOn;
   assign phaseB    = w_drive & w_hiSel[1] & w_pwmOn;
   assign phaseC    = w_drive & w_hiSel[0] & w_pwmOn;
   assign phaseA_lo = w_drive & w_loSel[2];
   assign phaseB_lo = w_drive & w_loSel[1];
   assign phaseC_lo = w_drive & w_loSel[0];
   assign fault     = (r_state == FAULT);

`ifdef BLDC_SPEED_MEAS_EN
   logic [SPD_W-1:0] r_spdCnt;
   logic [SPD_W-1:0] r_hallPeriod;
   logic             r_periodValid;
   logic             w_hallEvent;
   logic             w_inMotion;

   assign w_hallEvent = w_accept && (r_hallSync != r_accCode) &&
                        (r_hallSync != 3'b000) && (r_hallSync != 3'b111);
   assign w_inMotion  = (r_state == RUN) || (r_state == BLANK);

   // Saturating cycle count between accepted hall steps, published on each step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_spdCnt      <= '0;
         r_hallPeriod  <= '0;
         r_periodValid <= 1'b0;
      end else if (!w_inMotion) begin
         r_spdCnt      <= '0;
         r_periodValid <= 1'b0;
      end else if (w_hallEvent) begin
         r_hallPeriod  <= r_spdCnt;
         r_periodValid <= 1'b1;
         r_spdCnt      <= SPD_W'(1);
      end else begin
         r_periodValid <= 1'b0;
         if (r_spdCnt != {SPD_W{1'b1}})
            r_spdCnt <= r_spdCnt + 1'b1;
      end
   end

   assign hall_period  = r_hallPeriod;
   assign period_valid = r_periodValid;
`else
   assign hall_period  = '0;
   assign period_valid = 1'b0;
`endif

endmodule
